operand_fetch_seq: RTL and testbench
====================================

Name: operand_fetch_seq

Overview:
- Operand-fetch sequencer between decode and ALU.
- Takes two 5-bit operand pointers per instruction and resolves each through the shared constant LUT.
- If the LUT reports a register pointer, it issues a read on the single shared register-file read port.
- Returns both 8-bit operands, plus a pass-through tag, on a valid/ready output.

Parameters:
- DATA_W, 8, operand/constant width
- PTR_W, 5, operand pointer width; MSB=1 means constant, else register index
- TAG_W, 4, opaque tag carried from input to output (e.g. destination register)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of in-flight fetch; lower priority than Reset
- in_valid  in  1  instruction operands valid
- in_ready  out  1  sequencer can accept operands this cycle
- in_ptr_a  in  PTR_W  operand A pointer
- in_ptr_b  in  PTR_W  operand B pointer
- in_tag  in  TAG_W  tag
- lut_ptr  out  PTR_W  pointer to constant LUT
- lut_constant  in  DATA_W  LUT value, combinational from lut_ptr
- lut_const_flag  in  1  1 = lut_constant is a constant; 0 = pointer is a register index
- rf_re  out  1  register-file read enable
- rf_raddr  out  PTR_W-1  register-file read address
- rf_rdata  in  DATA_W  read data, valid the cycle after rf_re (synchronous read)
- out_valid  out  1  operands valid
- out_ready  in  1  consumer accepts
- out_opnd_a  out  DATA_W  operand A
- out_opnd_b  out  DATA_W  operand B
- out_tag  out  TAG_W  tag

Behaviour:
- Reset values: state=IDLE, out_valid=0, out_opnd_a=0, out_opnd_b=0, out_tag=0, latched pointers=0.
- At reset: rf_re=0, lut_ptr=0, in_ready=1.
- States: IDLE, A_SEL, A_WAIT, B_SEL, B_WAIT, OUT.
- in_ready = (state==IDLE) | (state==OUT & out_ready). Combinational.
- Accept (in_valid & in_ready): latch ptr_a, ptr_b, tag; go to A_SEL. This covers back-to-back issue from OUT.
- A_SEL: lut_ptr=ptr_a.
  - If lut_const_flag=1: opnd_a<=lut_constant, go to B_SEL.
  - Else: rf_re=1, rf_raddr=ptr_a[PTR_W-2:0], go to A_WAIT.
- A_WAIT: opnd_a<=rf_rdata; go to B_SEL.
- B_SEL / B_WAIT: same as A_SEL / A_WAIT for ptr_b into opnd_b; both exit to OUT.
- OUT: out_valid=1.
  - out_ready=1: go to A_SEL if a new accept occurs that cycle, else IDLE.
  - out_ready=0: hold; out_opnd_a/b and out_tag stay stable.
- rf_re is high only in A_SEL/B_SEL with a register pointer, for exactly one cycle per read. rf_raddr=0 when rf_re=0.
- lut_ptr=0 outside A_SEL/B_SEL.
- Latency from accept to out_valid:
  - 3 cycles: both constants
  - 4 cycles: one register
  - 5 cycles: both registers
- Pointer 5'b0xxxx is always treated per lut_const_flag. The sequencer does not decode the MSB itself.
- flush=1 in any state: go to IDLE next cycle, out_valid=0, in_ready=0 that cycle. Latched data is discarded; a read in flight is ignored.
- Reset mid-operation: same as flush, and registers return to reset values.
- Reset and flush both override a simultaneous accept.
- out_valid never drops without out_ready, except on flush or Reset.

Optional Feature:
- Macro: OPERAND_REUSE_EN.
- Defined: in B_SEL, if lut_const_flag=0, and A was a register read, and ptr_b==ptr_a:
  - opnd_b<=opnd_a, no rf_re, go directly to OUT.
  - Same-register latency becomes 4 cycles.
- Undefined: B is always re-read through the register file (5 cycles).

Test Plan:
- Reset held 2 cycles, then released → in_ready=1, out_valid=0, rf_re=0. Bench LUT model: 10100→8, 11101→255, 10001→1.
- ptr_a=5'b10100, ptr_b=5'b11101, tag=3 → out_valid 3 cycles after accept, opnd_a=8, opnd_b=255, tag=3, rf_re never asserted.
- ptr_a=5'b00010 (R2=0x3C), ptr_b=5'b10001 → rf_re one cycle with rf_raddr=2, out_valid at cycle 4, opnd_a=0x3C, opnd_b=1.
- ptr_a=ptr_b=5'b00101 (R5=0x77):
  - Without macro: two reads, out_valid at cycle 5.
  - With OPERAND_REUSE_EN: one read, out_valid at cycle 4.
  - Both give opnd_a=opnd_b=0x77.
- Hold out_ready=0 for 4 cycles in OUT → outputs stable. Then out_ready=1 with in_valid=1 → new accept same cycle, next state A_SEL.
- Assert flush during A_WAIT → next cycle IDLE, out_valid stays 0, stale rf_rdata not delivered. Same check with Reset instead of flush.

Source files
------------

// File: rtl/operand_fetch_seq.sv
// Operand-fetch sequencer: resolves two operand pointers through a shared constant LUT
// and one shared register-file read port. `define OPERAND_REUSE_EN to skip re-reading the same register for B.
module operand_fetch_seq #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 5,
  parameter int TAG_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PTR_W-1:0]  in_ptr_a,
  input  logic [PTR_W-1:0]  in_ptr_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [PTR_W-1:0]  lut_ptr,
  input  logic [DATA_W-1:0] lut_constant,
  input  logic              lut_const_flag,
  output logic              rf_re,
  output logic [PTR_W-2:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_opnd_a,
  output logic [DATA_W-1:0] out_opnd_b,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_SEL  = 3'd1,
    A_WAIT = 3'd2,
    B_SEL  = 3'd3,
    B_WAIT = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr_a;
  logic [PTR_W-1:0] ptr_b;
  logic             accept;
  logic             sel_phase;
  logic             reuse_b;
`ifdef OPERAND_REUSE_EN
  logic             a_is_reg;
`endif

  // B can reuse A's register value only when both resolved to the same register.
`ifdef OPERAND_REUSE_EN
  assign reuse_b = (state == B_SEL) && !lut_const_flag && a_is_reg && (ptr_b == ptr_a);
`else
  assign reuse_b = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    in_ready  = 1'b0;
    lut_ptr   = '0;
    rf_re     = 1'b0;
    rf_raddr  = '0;
    sel_phase = 1'b0;
    if (!Reset && !flush) begin
      in_ready = (state == IDLE) || ((state == OUT) && out_ready);
    end
    if (!Reset) begin
      case (state)
        A_SEL: begin
          lut_ptr   = ptr_a;
          sel_phase = 1'b1;
        end
        B_SEL: begin
          lut_ptr   = ptr_b;
          sel_phase = 1'b1;
        end
        default: begin
          lut_ptr   = '0;
          sel_phase = 1'b0;
        end
      endcase
    end
    // The LUT decides constant vs register; the pointer MSB is never decoded here.
    rf_re = sel_phase && !lut_const_flag && !reuse_b;
    if (rf_re) begin
      rf_raddr = lut_ptr[PTR_W-2:0];
    end
  end

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ptr_a      <= '0;
      ptr_b      <= '0;
      out_valid  <= 1'b0;
      out_opnd_a <= '0;
      out_opnd_b <= '0;
      out_tag    <= '0;
`ifdef OPERAND_REUSE_EN
      a_is_reg   <= 1'b0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        A_SEL: begin
          if (lut_const_flag) begin
            out_opnd_a <= lut_constant;
            state      <= B_SEL;
          end else begin
            state      <= A_WAIT;
          end
`ifdef OPERAND_REUSE_EN
          a_is_reg <= !lut_const_flag;
`endif
        end
        A_WAIT: begin
          out_opnd_a <= rf_rdata;
          state      <= B_SEL;
        end
        B_SEL: begin
          if (lut_const_flag) begin
            out_opnd_b <= lut_constant;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else if (reuse_b) begin
            out_opnd_b <= out_opnd_a;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else begin
            state      <= B_WAIT;
          end
        end
        B_WAIT: begin
          out_opnd_b <= rf_rdata;
          out_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
      // A new accept (from IDLE or back-to-back from OUT) overrides the transition above.
      if (accept) begin
        ptr_a   <= in_ptr_a;
        ptr_b   <= in_ptr_b;
        out_tag <= in_tag;
        state   <= A_SEL;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Self-checking bench for operand_fetch_seq: directed table, hand-written corner sequences
// and randomized transactions against a behavioural operand/latency model.
module tb_operand_fetch_seq;

`ifdef OPERAND_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_ptr_a;
  logic [4:0] in_ptr_b;
  logic [3:0] in_tag;
  logic [4:0] lut_ptr;
  logic [7:0] lut_constant;
  logic       lut_const_flag;
  logic       rf_re;
  logic [3:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_opnd_a;
  logic [7:0] out_opnd_b;
  logic [3:0] out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rf_mem [16];

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] tag;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    int         lat;
    int         reads;
  } vec_t;

  operand_fetch_seq dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ptr_a      (in_ptr_a),
    .in_ptr_b      (in_ptr_b),
    .in_tag        (in_tag),
    .lut_ptr       (lut_ptr),
    .lut_constant  (lut_constant),
    .lut_const_flag(lut_const_flag),
    .rf_re         (rf_re),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opnd_a    (out_opnd_a),
    .out_opnd_b    (out_opnd_b),
    .out_tag       (out_tag)
  );

  always #5 Clk = ~Clk;

  // Constant LUT: MSB=1 pointers plus one MSB=0 pointer (01111) are constants.
  function automatic logic lut_flag(input logic [4:0] p);
    return p[4] || (p == 5'b01111);
  endfunction

  function automatic logic [7:0] lut_val(input logic [4:0] p);
    logic [7:0] w;
    w = {3'b000, p};
    case (p)
      5'b10100: return 8'd8;
      5'b11101: return 8'd255;
      5'b10001: return 8'd1;
      5'b01111: return 8'hA5;
      default:  return w * 8'd13 + 8'd7;
    endcase
  endfunction

  always_comb begin
    lut_const_flag = lut_flag(lut_ptr);
    lut_constant   = lut_val(lut_ptr);
  end

  // Synchronous-read register file; garbage when no read is requested.
  always @(posedge Clk) begin
    if (rf_re) rf_rdata <= rf_mem[rf_raddr];
    else       rf_rdata <= 8'($urandom);
  end

  function automatic logic [7:0] opnd_val(input logic [4:0] p);
    return lut_flag(p) ? lut_val(p) : rf_mem[p[3:0]];
  endfunction

  function automatic vec_t model(input logic [4:0] a, input logic [4:0] b, input logic [3:0] tag);
    vec_t v;
    v.a     = a;
    v.b     = b;
    v.tag   = tag;
    v.exp_a = opnd_val(a);
    v.exp_b = opnd_val(b);
    v.reads = int'(!lut_flag(a)) + int'(!lut_flag(b));
    if (REUSE && !lut_flag(a) && !lut_flag(b) && a == b) v.reads = v.reads - 1;
    v.lat   = 3 + v.reads;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a transaction at a negedge; valid from IDLE or back-to-back from OUT.
  task automatic issue(input vec_t v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_ptr_a  = v.a;
    in_ptr_b  = v.b;
    in_tag    = v.tag;
    #1;
    check("accept_in_ready", in_ready, 1);
    @(posedge Clk);
  endtask

  // Follow the transaction from the accept edge to OUT, then hold out_ready low.
  task automatic collect(input vec_t v, input int hold);
    int         lat;
    bit         idle_addr_ok;
    bit         stable;
    logic [3:0] got_addr[$];
    logic [3:0] want_addr[$];
    lat = 0;
    idle_addr_ok = 1'b1;
    if (!lut_flag(v.a)) want_addr.push_back(v.a[3:0]);
    if (!lut_flag(v.b) && !(REUSE && !lut_flag(v.a) && v.a == v.b)) want_addr.push_back(v.b[3:0]);
    do begin
      @(negedge Clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      lat++;
      if (lat == 1) check("a_sel_lut_ptr", lut_ptr, v.a);
      if (rf_re) got_addr.push_back(rf_raddr);
      else if (rf_raddr != 0) idle_addr_ok = 1'b0;
    end while (!out_valid && lat < 30);
    check("latency", lat, v.lat);
    check("rf_reads", got_addr.size(), v.reads);
    for (int i = 0; i < want_addr.size() && i < got_addr.size(); i++)
      check("rf_raddr", got_addr[i], want_addr[i]);
    check("rf_raddr_idle_zero", idle_addr_ok, 1);
    check("opnd_a", out_opnd_a, v.exp_a);
    check("opnd_b", out_opnd_b, v.exp_b);
    check("tag", out_tag, v.tag);
    stable = 1'b1;
    repeat (hold) begin
      @(negedge Clk);
      if (!out_valid || out_opnd_a !== v.exp_a || out_opnd_b !== v.exp_b || out_tag !== v.tag)
        stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  // Abort a register fetch while its read is in flight (A_WAIT).
  task automatic abort_test(input bit use_reset);
    bit quiet;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_ptr_a  = 5'b00010;
    in_ptr_b  = 5'b10001;
    in_tag    = 4'hC;
    @(posedge Clk);
    @(negedge Clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("abort_a_sel_rf_re", rf_re, 1);
    @(negedge Clk);
    if (use_reset) Reset = 1'b1;
    else           flush = 1'b1;
    #1;
    check("abort_in_ready_low", in_ready, 0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    flush = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_idle_in_ready", in_ready, 1);
    check("abort_rf_re", rf_re, 0);
    check("abort_lut_ptr", lut_ptr, 0);
    if (use_reset) begin
      check("reset_opnd_a", out_opnd_a, 0);
      check("reset_opnd_b", out_opnd_b, 0);
      check("reset_tag", out_tag, 0);
    end
    quiet = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      if (out_valid) quiet = 1'b0;
    end
    check("abort_no_stale_output", quiet, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [4:0] ra;
    logic [4:0] rb;

    for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 29 + 11);
    rf_mem[2] = 8'h3C;
    rf_mem[5] = 8'h77;

    tbl[0] = '{5'b10100, 5'b11101, 4'd3,  8'd8,   8'd255, 3, 0};
    tbl[1] = '{5'b00010, 5'b10001, 4'd5,  8'h3C,  8'd1,   4, 1};
    tbl[2] = '{5'b00101, 5'b00101, 4'd9,  8'h77,  8'h77,  REUSE ? 4 : 5, REUSE ? 1 : 2};
    tbl[3] = '{5'b01111, 5'b00010, 4'd1,  8'hA5,  8'h3C,  4, 1};
    tbl[4] = '{5'b00101, 5'b00010, 4'd15, 8'h77,  8'h3C,  5, 2};
    tbl[5] = '{5'b11101, 5'b00101, 4'd0,  8'd255, 8'h77,  4, 1};

    Reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ptr_a  = '0;
    in_ptr_b  = '0;
    in_tag    = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rf_re", rf_re, 0);
    check("rst_lut_ptr", lut_ptr, 0);
    check("rst_opnd_a", out_opnd_a, 0);
    check("rst_opnd_b", out_opnd_b, 0);
    check("rst_tag", out_tag, 0);

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i]);
      collect(tbl[i], i % 3);
      release_out();
    end

    // Four-cycle stall in OUT, then back-to-back accept on the releasing cycle.
    issue(tbl[0]);
    collect(tbl[0], 4);
    issue(tbl[1]);
    collect(tbl[1], 0);
    release_out();

    abort_test(1'b0);
    abort_test(1'b1);
    issue(tbl[4]);
    collect(tbl[4], 1);
    release_out();

    for (int n = 0; n < 40; n++) begin
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      v  = model(ra, rb, 4'($urandom));
      if ($urandom_range(0, 1) == 1) release_out();
      issue(v);
      collect(v, int'($urandom_range(0, 3)));
    end
    release_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
